// File: rtl/k_energy_pkg.sv
// Shared constants for the complex-sample frame energy accumulator.
// Output-FSM states and width derivations used by the pipe and the top.
package k_energy_pkg;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_e;

  // re^2 + im^2 needs one bit above a single square
  localparam int PWR_GUARD = 1;

  function automatic int sq_width(input int in_w);
    return 2 * in_w;
  endfunction

  function automatic int pwr_width(input int in_w);
    return sq_width(in_w) + PWR_GUARD;
  endfunction

endpackage

// File: rtl/k_cplx_power_pipe.sv
// Three-stage |x|^2 pipe: capture, square, sum.
// Valid and last ride alongside the data; all stages freeze when en_i is low.
module k_cplx_power_pipe
  import k_energy_pkg::*;
#(
  parameter int IN_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          aresetn,
  input  logic                          en_i,
  input  logic                          valid_i,
  input  logic                          last_i,
  input  logic [IN_WIDTH-1:0]           re_i,
  input  logic [IN_WIDTH-1:0]           im_i,
  output logic                          valid_o,
  output logic                          last_o,
  output logic [pwr_width(IN_WIDTH)-1:0] pwr_o
);

  localparam int SW = sq_width(IN_WIDTH);
  localparam int PW = pwr_width(IN_WIDTH);

  logic [IN_WIDTH-1:0] re_q, im_q;
  logic                v1_q, l1_q;
  logic [SW-1:0]       re_x, im_x;
  logic [SW-1:0]       sq_re_d, sq_im_d;
  logic [SW-1:0]       sq_re_q, sq_im_q;
  logic                v2_q, l2_q;
  logic [PW-1:0]       pwr_d, pwr_q;
  logic                v3_q, l3_q;

  // Sign-extend before squaring so the low 2W bits are the exact product
  assign re_x = {{IN_WIDTH{re_q[IN_WIDTH-1]}}, re_q};
  assign im_x = {{IN_WIDTH{im_q[IN_WIDTH-1]}}, im_q};

  assign sq_re_d = re_x * re_x;
  assign sq_im_d = im_x * im_x;
  assign pwr_d   = {1'b0, sq_re_q} + {1'b0, sq_im_q};

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      re_q    <= '0;
      im_q    <= '0;
      v1_q    <= 1'b0;
      l1_q    <= 1'b0;
      sq_re_q <= '0;
      sq_im_q <= '0;
      v2_q    <= 1'b0;
      l2_q    <= 1'b0;
      pwr_q   <= '0;
      v3_q    <= 1'b0;
      l3_q    <= 1'b0;
    end else if (en_i) begin
      re_q    <= re_i;
      im_q    <= im_i;
      v1_q    <= valid_i;
      l1_q    <= last_i;
      sq_re_q <= sq_re_d;
      sq_im_q <= sq_im_d;
      v2_q    <= v1_q;
      l2_q    <= l1_q;
      pwr_q   <= pwr_d;
      v3_q    <= v2_q;
      l3_q    <= l2_q;
    end
  end

  assign valid_o = v3_q;
  assign last_o  = l3_q;
  assign pwr_o   = pwr_q;

endmodule

// File: rtl/k_energy_accumulator.sv
// Frame energy accumulator over complex samples with saturation,
// forced frame end at 2^MAX_FRAME_LOG2 samples and a one-deep result register.
module k_energy_accumulator
  import k_energy_pkg::*;
#(
  parameter int IN_WIDTH       = 16,
  parameter int ACC_WIDTH      = 48,
  parameter int MAX_FRAME_LOG2 = 10
) (
  input  logic                      clk,
  input  logic                      aresetn,
  input  logic                      s_axis_tvalid,
  output logic                      s_axis_tready,
  input  logic [2*IN_WIDTH-1:0]     s_axis_tdata,
  input  logic                      s_axis_tlast,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  output logic [ACC_WIDTH-1:0]      m_axis_tdata,
  output logic [MAX_FRAME_LOG2:0]   m_axis_tcount,
  output logic                      m_axis_tsat
);

  localparam int PW = pwr_width(IN_WIDTH);
  localparam int CW = MAX_FRAME_LOG2 + 1;
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_MAX = {1'b1, {MAX_FRAME_LOG2{1'b0}}};

  logic                 en;
  logic                 p_valid, p_last;
  logic [PW-1:0]        p_pwr;

  logic [ACC_WIDTH:0]   sum_w;
  logic                 ovf;
  logic [ACC_WIDTH-1:0] sat_val;
  logic [CW-1:0]        cnt_inc;
  logic                 fe, accum;

  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 ssat_q, ssat_d;
  logic [ACC_WIDTH-1:0] dat_q, dat_d;
  logic [CW-1:0]        ocnt_q, ocnt_d;
  logic                 osat_q, osat_d;
  out_state_e           state_q, state_d;

  assign en            = !(m_axis_tvalid && !m_axis_tready);
  assign s_axis_tready = en;

  k_cplx_power_pipe #(
    .IN_WIDTH (IN_WIDTH)
  ) u_pipe (
    .clk     (clk),
    .aresetn (aresetn),
    .en_i    (en),
    .valid_i (s_axis_tvalid),
    .last_i  (s_axis_tlast),
    .re_i    (s_axis_tdata[2*IN_WIDTH-1:IN_WIDTH]),
    .im_i    (s_axis_tdata[IN_WIDTH-1:0]),
    .valid_o (p_valid),
    .last_o  (p_last),
    .pwr_o   (p_pwr)
  );

  // One spare bit on the add exposes overflow for the clamp
  assign sum_w   = {1'b0, acc_q} + {{(ACC_WIDTH+1-PW){1'b0}}, p_pwr};
  assign ovf     = sum_w[ACC_WIDTH];
  assign sat_val = ovf ? '1 : sum_w[ACC_WIDTH-1:0];
  assign cnt_inc = cnt_q + CNT_ONE;

  assign fe    = en && p_valid && (p_last || (cnt_inc == CNT_MAX));
  assign accum = en && p_valid && !fe;

  always_comb begin
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    ssat_d = ssat_q;
    dat_d  = dat_q;
    ocnt_d = ocnt_q;
    osat_d = osat_q;
    unique case (1'b1)
      fe: begin
        acc_d  = '0;
        cnt_d  = '0;
        ssat_d = 1'b0;
        dat_d  = sat_val;
        ocnt_d = cnt_inc;
        osat_d = ssat_q | ovf;
      end
      accum: begin
        acc_d  = sat_val;
        cnt_d  = cnt_inc;
        ssat_d = ssat_q | ovf;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      acc_q  <= '0;
      cnt_q  <= '0;
      ssat_q <= 1'b0;
      dat_q  <= '0;
      ocnt_q <= '0;
      osat_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      ssat_q <= ssat_d;
      dat_q  <= dat_d;
      ocnt_q <= ocnt_d;
      osat_q <= osat_d;
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) state_q <= OUT_EMPTY;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      OUT_EMPTY: if (fe) state_d = OUT_FULL;
      OUT_FULL:  if (!fe && m_axis_tready) state_d = OUT_EMPTY;
      default:   state_d = OUT_EMPTY;
    endcase
  end

  always_comb begin
    m_axis_tvalid = (state_q == OUT_FULL);
    m_axis_tdata  = dat_q;
    m_axis_tcount = ocnt_q;
    m_axis_tsat   = osat_q;
  end

endmodule

// File: doc/k_energy_accumulator.md
K_ENERGY_ACCUMULATOR -- requirements
Module: k_energy_accumulator

Interface
REQ-001 SHALL have parameter IN_WIDTH, default 16: width of each signed I/Q component.
REQ-002 SHALL have parameter ACC_WIDTH, default 48: frame-energy accumulator and output width; ACC_WIDTH >= 2*IN_WIDTH+1.
REQ-003 SHALL have parameter MAX_FRAME_LOG2, default 10: forced frame end after 2^MAX_FRAME_LOG2 samples.
REQ-004 SHALL have port clk, input, 1: the single clock; one clock, all logic on its rising edge.
REQ-005 SHALL have port aresetn, input, 1: reset, asynchronous and active-low.
REQ-006 SHALL have port s_axis_tvalid, input, 1: input sample valid.
REQ-007 SHALL have port s_axis_tready, output, 1: input sample accepted when high with tvalid.
REQ-008 SHALL have port s_axis_tdata, input, 2*IN_WIDTH: signed re in [2*IN_WIDTH-1:IN_WIDTH], signed im in [IN_WIDTH-1:0].
REQ-009 SHALL have port s_axis_tlast, input, 1: marks the last sample of a frame.
REQ-010 SHALL have port m_axis_tvalid, output, 1: frame result valid.
REQ-011 SHALL have port m_axis_tready, input, 1: downstream accepts the result.
REQ-012 SHALL have port m_axis_tdata, output, ACC_WIDTH: unsigned frame energy, sum of re^2+im^2.
REQ-013 SHALL have port m_axis_tcount, output, MAX_FRAME_LOG2+1: number of samples in the reported frame.
REQ-014 SHALL have port m_axis_tsat, output, 1: the accumulator saturated during the reported frame.

Function
REQ-015 Pipeline enable en = !(m_axis_tvalid && !m_axis_tready); s_axis_tready SHALL equal en; while en is low, all pipeline stages, the accumulator and the counter SHALL hold.
REQ-016 Stage 1 (accept edge): register re, im, last, valid.
REQ-017 Stage 2: compute signed re*re and im*im, each held as 2*IN_WIDTH-bit unsigned; (-2^(IN_WIDTH-1))^2 SHALL be exact.
REQ-018 Stage 3: compute p = re^2 + im^2 at 2*IN_WIDTH+1 bits with no loss.
REQ-019 Stage 4: for a valid non-last sample, acc <= sat(acc+p) and cnt <= cnt+1.
REQ-020 Stage 4 frame end: triggered by last, or by cnt+1 == 2^MAX_FRAME_LOG2; it SHALL load m_axis_tdata=sat(acc+p), m_axis_tcount=cnt+1, m_axis_tsat=(sticky sat OR this add saturated), set m_axis_tvalid, and clear acc, cnt and sticky sat.
REQ-021 sat(x) SHALL clamp to 2^ACC_WIDTH-1 and set the sticky sat flag.
REQ-022 Latency: m_axis_tvalid SHALL be high after the 4th rising edge, counting the accept edge of the frame-ending sample as the first, with no stall.
REQ-023 Throughput: one sample per cycle while m_axis_tready is high or the output is empty.
REQ-024 Output FSM: OUT_EMPTY -> OUT_FULL on frame end; OUT_FULL -> OUT_EMPTY on m_axis_tready, unless a new frame end occurs in the same cycle, which stays OUT_FULL with the new data; data SHALL be stable while OUT_FULL and not ready.
REQ-025 A tlast sample that also hits the forced limit SHALL produce exactly one result.
REQ-026 A single-sample frame (tlast on the first sample) SHALL report tcount=1.

Reset
REQ-027 While aresetn is low: m_axis_tvalid=0, m_axis_tdata=0, m_axis_tcount=0, m_axis_tsat=0, all stage valids 0, acc=0, cnt=0, sticky sat=0.
REQ-028 s_axis_tready SHALL be 1 during and after reset, since the output is empty.
REQ-029 Reset mid-frame SHALL discard the partial frame and any in-flight samples; the first sample after release starts a new frame.

Structure
REQ-030 Package k_energy_pkg SHALL hold the output-FSM state constants (OUT_EMPTY, OUT_FULL) and width-derivation constants (power width 2*IN_WIDTH+1).
REQ-031 Sub-module k_cplx_power_pipe SHALL implement stages 1-3 with an enable input and valid/last sideband; the top SHALL hold the accumulator, counter, saturation and output register.

Verification
REQ-032 Single frame: (3,4),(1,-1),(0,2) with tlast on the 3rd sample, ready=1 -> tdata=31, tcount=3, tsat=0, valid 4 edges after the 3rd accept.
REQ-033 Extremes: IN_WIDTH=16, sample (-32768,-32768) with tlast -> tdata=2^31, tcount=1.
REQ-034 Forced end: MAX_FRAME_LOG2=2, 6 samples (1,0) with no tlast -> first result tdata=4, tcount=4; the next frame holds 2 samples and stays open.
REQ-035 Backpressure: m_axis_tready=0 for 10 cycles with a result pending -> s_axis_tready=0, tdata stable, no sample lost; a later frame is correct.
REQ-036 Saturation: ACC_WIDTH=33, 4 samples (-32768,-32768) with tlast -> tdata=2^33-1, tsat=1; the next frame reports tsat=0.
REQ-037 Reset mid-frame: 2 samples, aresetn pulse low, then (1,1) with tlast -> tdata=2, tcount=1.
